// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle between the execute stage and fpu_issue_ctrl.
interface fpu_issue_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [31:0] rs3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_int_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, instr_i, rs1_i, rs2_i, rs3_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_int_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, instr_i, rs1_i, rs2_i, rs3_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_rd_o, rsp_int_o, rsp_err_o
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer for the RV32F datapath: accepts one instruction, times
// single-cycle / fixed-latency / iterative operations, returns the result.
module fpu_issue_ctrl #(
    parameter int unsigned ARITH_LAT    = 2,
    parameter int unsigned ITER_TIMEOUT = 64,
    parameter logic [31:0] CANON_NAN    = 32'h7FC00000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    fpu_issue_ctrl_if.slave       bus,
    output logic [31:0]           fpu_instr_o,
    output logic [31:0]           fpu_rs1_o,
    output logic [31:0]           fpu_rs2_o,
    output logic [31:0]           fpu_rs3_o,
    input  logic [31:0]           fpu_result_i,
    output logic                  iter_start_o,
    output logic                  iter_abort_o,
    input  logic                  iter_done_i,
    input  logic [31:0]           iter_result_i,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(ARITH_LAT + 1);
    localparam int unsigned TMR_W = $clog2(ITER_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_ITER, RESP} state_t;
    typedef enum logic [1:0] {CLS_S, CLS_A, CLS_I, CLS_ILL} cls_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               illegal_q, illegal_d;
    logic [31:0]        instr_q, instr_d, rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               iter_start_q, iter_start_d;
    logic               iter_abort_q, iter_abort_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [4:0]         rsp_rd_q, rsp_rd_d;
    logic               rsp_int_q, rsp_int_d;
    logic               rsp_err_q, rsp_err_d;

    cls_t               dec_cls;
    logic               dec_int;

    // Decode the incoming instruction into timing class and target register file.
    always_comb begin
        dec_cls = CLS_ILL;
        dec_int = 1'b0;
        if (!bus.instr_i[4]) begin
            dec_cls = CLS_A;
        end else begin
            case (bus.instr_i[31:27])
                5'b00000, 5'b00001, 5'b00010, 5'b11010: dec_cls = CLS_A;
                5'b11000: begin dec_cls = CLS_A; dec_int = 1'b1; end
                5'b00011, 5'b01011:                      dec_cls = CLS_I;
                5'b00100, 5'b00101, 5'b11110:            dec_cls = CLS_S;
                5'b10100, 5'b11100: begin dec_cls = CLS_S; dec_int = 1'b1; end
                default:                                 dec_cls = CLS_ILL;
            endcase
        end
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        timer_d      = timer_q;
        illegal_d    = illegal_q;
        instr_d      = instr_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rs3_d        = rs3_q;
        req_ready_d  = req_ready_q;
        busy_d       = busy_q;
        iter_start_d = 1'b0;
        iter_abort_d = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_rd_d     = rsp_rd_q;
        rsp_int_d    = rsp_int_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    instr_d     = bus.instr_i;
                    rs1_d       = bus.rs1_i;
                    rs2_d       = bus.rs2_i;
                    rs3_d       = bus.rs3_i;
                    rsp_rd_d    = bus.instr_i[11:7];
                    rsp_int_d   = dec_int;
                    illegal_d   = (dec_cls == CLS_ILL);
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    case (dec_cls)
                        CLS_I: begin
                            state_d      = WAIT_ITER;
                            timer_d      = '0;
                            iter_start_d = 1'b1;
                        end
                        CLS_A: begin
                            state_d = EXEC;
                            count_d = CNT_W'(ARITH_LAT);
                        end
                        default: begin
                            state_d = EXEC;
                            count_d = CNT_W'(1);
                        end
                    endcase
                end
            end
            EXEC: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = illegal_q ? '0 : fpu_result_i;
                    rsp_err_d   = illegal_q;
                end
            end
            WAIT_ITER: begin
                timer_d = timer_q + TMR_W'(1);
                // A done pulse in the final timeout cycle takes priority over the abort.
                if (iter_done_i) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = iter_result_i;
                    rsp_err_d   = 1'b0;
                end else if (timer_q == TMR_W'(ITER_TIMEOUT - 1)) begin
                    state_d      = RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = CANON_NAN;
                    rsp_err_d    = 1'b1;
                    iter_abort_d = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any operation without an abort.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            timer_q      <= '0;
            illegal_q    <= 1'b0;
            instr_q      <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs3_q        <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            iter_start_q <= 1'b0;
            iter_abort_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_rd_q     <= '0;
            rsp_int_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            illegal_q    <= illegal_d;
            instr_q      <= instr_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rs3_q        <= rs3_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            iter_start_q <= iter_start_d;
            iter_abort_q <= iter_abort_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_int_q    <= rsp_int_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_rd_o    = rsp_rd_q;
    assign bus.rsp_int_o   = rsp_int_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign fpu_instr_o     = instr_q;
    assign fpu_rs1_o       = rs1_q;
    assign fpu_rs2_o       = rs2_q;
    assign fpu_rs3_o       = rs3_q;
    assign iter_start_o    = iter_start_q;
    assign iter_abort_o    = iter_abort_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl.
module tb_fpu_issue_ctrl;

    localparam int unsigned ITO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fpu_instr, fpu_rs1, fpu_rs2, fpu_rs3, fpu_result;
    logic        iter_start, iter_abort, iter_done, busy;
    logic [31:0] iter_result;
    int          checks = 0;
    int          errors = 0;
    int          early;

    always #5 clk = ~clk;

    fpu_issue_ctrl_if bus ();

    fpu_issue_ctrl #(
        .ARITH_LAT   (2),
        .ITER_TIMEOUT(ITO),
        .CANON_NAN   (32'h7FC00000)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .bus          (bus.slave),
        .fpu_instr_o  (fpu_instr),
        .fpu_rs1_o    (fpu_rs1),
        .fpu_rs2_o    (fpu_rs2),
        .fpu_rs3_o    (fpu_rs3),
        .fpu_result_i (fpu_result),
        .iter_start_o (iter_start),
        .iter_abort_o (iter_abort),
        .iter_done_i  (iter_done),
        .iter_result_i(iter_result),
        .busy_o       (busy)
    );

    // Tiny combinational FPU model covering the operations used below.
    always_comb begin
        fpu_result = 32'hDEADBEEF;
        case (fpu_instr[31:27])
            5'b00100: fpu_result = {fpu_rs2[31], fpu_rs1[30:0]};
            5'b00010: if (fpu_rs1 == 32'h40000000 && fpu_rs2 == 32'h40400000) fpu_result = 32'h40C00000;
            5'b10100: fpu_result = {31'b0, fpu_rs1 == fpu_rs2};
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] op_fp(input logic [4:0] f5, input logic [2:0] f3, input logic [4:0] rd);
        return {f5, 2'b00, 5'd0, 5'd0, f3, rd, 7'b1010011};
    endfunction

    task automatic accept(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bus.req_valid_i = 1'b1;
        bus.instr_i     = ins;
        bus.rs1_i       = a;
        bus.rs2_i       = b;
        bus.rs3_i       = c;
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.instr_i     = '0;
        bus.rs1_i       = '0;
        bus.rs2_i       = '0;
        bus.rs3_i       = '0;
        bus.rsp_ready_i = 1'b0;
        iter_done       = 1'b0;
        iter_result     = '0;
        tick();
        check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fpu_instr", fpu_instr, 32'd0);
        check("rst_rsp_data", bus.rsp_data_o, 32'd0);
        rst = 1'b0;
        tick();

        // FSGNJ: single-cycle class
        accept(32'h20000053, 32'h3F800000, 32'h80000000, 32'd0);
        check("sgnj_busy", 32'(busy), 32'd1);
        check("sgnj_no_rsp_yet", 32'(bus.rsp_valid_o), 32'd0);
        check("sgnj_req_ready", 32'(bus.req_ready_o), 32'd0);
        check("sgnj_fpu_instr", fpu_instr, 32'h20000053);
        check("sgnj_fpu_rs1", fpu_rs1, 32'h3F800000);
        tick();
        check("sgnj_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("sgnj_data", bus.rsp_data_o, 32'hBF800000);
        check("sgnj_int", 32'(bus.rsp_int_o), 32'd0);
        check("sgnj_err", 32'(bus.rsp_err_o), 32'd0);
        check("sgnj_rd", 32'(bus.rsp_rd_o), 32'd0);
        handshake("sgnj");

        // FMUL: ARITH_LAT=2, response held under back-pressure
        accept(op_fp(5'b00010, 3'b000, 5'd5), 32'h40000000, 32'h40400000, 32'h12345678);
        check("fmul_rd_at_accept", 32'(bus.rsp_rd_o), 32'd5);
        check("fmul_rs3", fpu_rs3, 32'h12345678);
        check("fmul_no_rsp_1", 32'(bus.rsp_valid_o), 32'd0);
        tick();
        check("fmul_no_rsp_2", 32'(bus.rsp_valid_o), 32'd0);
        tick();
        check("fmul_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("fmul_data", bus.rsp_data_o, 32'h40C00000);
        // Present the next request while stalled: it must not be consumed.
        bus.req_valid_i = 1'b1;
        bus.instr_i     = op_fp(5'b10100, 3'b010, 5'd10);
        bus.rs1_i       = 32'h3F800000;
        bus.rs2_i       = 32'h3F800000;
        bus.rs3_i       = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fmul_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("fmul_hold_data", bus.rsp_data_o, 32'h40C00000);
            check("fmul_hold_rd", 32'(bus.rsp_rd_o), 32'd5);
            check("fmul_hold_req_ready", 32'(bus.req_ready_o), 32'd0);
            check("fmul_hold_fpu_rs1", fpu_rs1, 32'h40000000);
        end
        // Handshake edge with req_valid still high: no accept in the same edge.
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check("fmul_valid_drop", 32'(bus.rsp_valid_o), 32'd0);
        check("fmul_no_same_edge_accept", 32'(busy), 32'd0);
        check("fmul_req_ready_back", 32'(bus.req_ready_o), 32'd1);
        check("fmul_fpu_instr_kept", fpu_instr, op_fp(5'b00010, 3'b000, 5'd5));

        // FEQ accepted on the following edge
        tick();
        bus.req_valid_i = 1'b0;
        check("feq_fpu_instr", fpu_instr, op_fp(5'b10100, 3'b010, 5'd10));
        check("feq_busy", 32'(busy), 32'd1);
        tick();
        check("feq_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("feq_data", bus.rsp_data_o, 32'd1);
        check("feq_int", 32'(bus.rsp_int_o), 32'd1);
        check("feq_rd", 32'(bus.rsp_rd_o), 32'd10);
        check("feq_err", 32'(bus.rsp_err_o), 32'd0);
        handshake("feq");

        // FDIV: done arrives 10 cycles after the start pulse
        accept(op_fp(5'b00011, 3'b000, 5'd7), 32'h3F800000, 32'h40000000, 32'd0);
        check("fdiv_start", 32'(iter_start), 32'd1);
        tick();
        check("fdiv_start_one_pulse", 32'(iter_start), 32'd0);
        repeat (9) tick();
        check("fdiv_waiting", 32'(bus.rsp_valid_o), 32'd0);
        iter_done   = 1'b1;
        iter_result = 32'h3F000000;
        tick();
        iter_done   = 1'b0;
        iter_result = 32'd0;
        check("fdiv_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("fdiv_data", bus.rsp_data_o, 32'h3F000000);
        check("fdiv_err", 32'(bus.rsp_err_o), 32'd0);
        check("fdiv_abort", 32'(iter_abort), 32'd0);
        check("fdiv_rd", 32'(bus.rsp_rd_o), 32'd7);
        handshake("fdiv");

        // Spurious done while idle
        iter_done = 1'b1;
        tick();
        iter_done = 1'b0;
        check("spur_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("spur_busy", 32'(busy), 32'd0);
        tick();
        check("spur_valid_later", 32'(bus.rsp_valid_o), 32'd0);

        // FSQRT timeout
        accept(op_fp(5'b01011, 3'b000, 5'd3), 32'h40000000, 32'd0, 32'd0);
        early = 0;
        for (int i = 0; i < ITO - 1; i++) begin
            tick();
            if (iter_abort || bus.rsp_valid_o) early++;
        end
        check("tmo_no_early_end", 32'(early), 32'd0);
        tick();
        check("tmo_abort", 32'(iter_abort), 32'd1);
        check("tmo_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("tmo_data", bus.rsp_data_o, 32'h7FC00000);
        check("tmo_err", 32'(bus.rsp_err_o), 32'd1);
        tick();
        check("tmo_abort_one_pulse", 32'(iter_abort), 32'd0);
        check("tmo_err_held", 32'(bus.rsp_err_o), 32'd1);
        handshake("tmo");
        check("tmo_err_drop", 32'(bus.rsp_err_o), 32'd0);

        // FSQRT with done in the last timeout cycle
        accept(op_fp(5'b01011, 3'b000, 5'd4), 32'h40000000, 32'd0, 32'd0);
        repeat (ITO - 1) tick();
        check("edge_not_done_yet", 32'(bus.rsp_valid_o), 32'd0);
        iter_done   = 1'b1;
        iter_result = 32'h3FB504F3;
        tick();
        iter_done   = 1'b0;
        iter_result = 32'd0;
        check("edge_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("edge_data", bus.rsp_data_o, 32'h3FB504F3);
        check("edge_err", 32'(bus.rsp_err_o), 32'd0);
        check("edge_abort", 32'(iter_abort), 32'd0);
        handshake("edge");

        // Illegal funct5
        accept(op_fp(5'b11111, 3'b000, 5'd9), 32'h3F800000, 32'h3F800000, 32'd0);
        tick();
        check("ill_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("ill_err", 32'(bus.rsp_err_o), 32'd1);
        check("ill_data", bus.rsp_data_o, 32'd0);
        check("ill_int", 32'(bus.rsp_int_o), 32'd0);
        handshake("ill");
        check("ill_err_drop", 32'(bus.rsp_err_o), 32'd0);

        // Reset during WAIT_ITER
        accept(op_fp(5'b00011, 3'b000, 5'd6), 32'h40400000, 32'h40000000, 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_req_ready", 32'(bus.req_ready_o), 32'd1);
        check("mrst_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("mrst_abort", 32'(iter_abort), 32'd0);
        check("mrst_fpu_instr", fpu_instr, 32'd0);
        check("mrst_fpu_rs1", fpu_rs1, 32'd0);
        check("mrst_rsp_rd", 32'(bus.rsp_rd_o), 32'd0);
        tick();
        check("mrst_abort_later", 32'(iter_abort), 32'd0);
        accept(op_fp(5'b10100, 3'b010, 5'd12), 32'h40400000, 32'h40400000, 32'd0);
        tick();
        check("post_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("post_data", bus.rsp_data_o, 32'd1);
        check("post_rd", 32'(bus.rsp_rd_o), 32'd12);
        check("post_int", 32'(bus.rsp_int_o), 32'd1);
        handshake("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequencer between the core's execute stage and the RV32F datapath. It accepts one FP instruction at a time via valid/ready and registers the instruction and operands into the combinational FPU. It times single-cycle, fixed-latency and iterative (FDIV/FSQRT) operations, then returns the result with destination info via a valid/ready response port. It drives busy to stall the pipeline while an operation is outstanding.

Parameters:
ARITH_LAT, 2, cycles from accept to result capture for FADD/FSUB/FMUL/FMA/FCVT (min 1)
ITER_TIMEOUT, 64, max cycles waiting for iter_done_i before aborting
CANON_NAN, 32'h7FC00000, data returned on timeout

Ports:
clk_i  in  1  clock, all logic rising-edge
reset_i  in  1  synchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready at a rising edge
instr_i  in  32  RV32F instruction word
rs1_i / rs2_i / rs3_i  in  32 each  source operands
fpu_instr_o  out  32  registered instruction to datapath
fpu_rs1_o / fpu_rs2_o / fpu_rs3_o  out  32 each  registered operands to datapath
fpu_result_i  in  32  combinational datapath result
iter_start_o  out  1  one-cycle start pulse to iterative div/sqrt unit
iter_abort_o  out  1  one-cycle abort pulse on timeout
iter_done_i  in  1  iterative unit result valid (single-cycle pulse)
iter_result_i  in  32  iterative unit result
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready at a rising edge
rsp_data_o  out  32  result
rsp_rd_o  out  5  destination register (instr[11:7])
rsp_int_o  out  1  1 = write integer file (FEQ/FLT/FLE/FCLASS/FCVT.W[U].S/FMV.X.W)
rsp_err_o  out  1  1 = illegal encoding or timeout
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: clk_i is the only clock; reset_i is synchronous and active-high. When reset_i is sampled high, state goes to IDLE and every output is 0 except req_ready_o=1. All registered operands and instruction are 0. Reset mid-operation drops the operation silently and raises no iter_abort_o.
- States: IDLE, EXEC, WAIT_ITER, RESP.
- IDLE: req_ready_o=1. On accept, register instr/operands onto fpu_*_o and classify:
  - Class S (FSGNJ*, FMIN/FMAX, FEQ/FLT/FLE, FCLASS, FMV.X.W, FMV.W.X): go to EXEC, count=1.
  - Class A (FADD, FSUB, FMUL, FMA opcodes instr[4]=0, FCVT.W[U].S, FCVT.S.W[U]): go to EXEC, count=ARITH_LAT.
  - Class I (FDIV funct5 00011, FSQRT 01011): go to WAIT_ITER, pulse iter_start_o in the first WAIT_ITER cycle, clear timer.
  - Any other funct5 (with instr[4]=1): go to EXEC, count=1, flag illegal.
- EXEC: count decrements each cycle. In the cycle where count==1, at the next edge capture rsp_data_o and go to RESP.
  - Normal capture: rsp_data_o=fpu_result_i.
  - Illegal: rsp_data_o=0, rsp_err_o=1.
  - rsp_valid_o therefore rises N edges after the accept edge (N=1 for S, ARITH_LAT for A).
- WAIT_ITER: timer increments each cycle.
  - iter_done_i=1: capture iter_result_i, go to RESP.
  - Else if timer==ITER_TIMEOUT-1: rsp_data_o=CANON_NAN, rsp_err_o=1, iter_abort_o pulses one cycle, go to RESP.
  - iter_done_i in the timeout cycle wins; no error.
- RESP: rsp_valid_o=1. rsp_data_o, rsp_rd_o, rsp_int_o and rsp_err_o are held stable until the handshake. On rsp_ready_i: go to IDLE and drop rsp_valid_o and rsp_err_o. No new request is accepted in the same edge; req_ready_o rises the following cycle.
- rsp_rd_o and rsp_int_o are captured at accept and remain valid through RESP.
- iter_done_i outside WAIT_ITER is ignored.
- req_valid_i while not IDLE is ignored and the request is not consumed.
- fpu_*_o hold the last accepted values until the next accept.
- busy_o = (state != IDLE), registered with the state.

Test Plan:
- FSGNJ: instr=32'h20000053 (rd=0), rs1=3F800000, rs2=80000000, bench FPU model returns BF800000 → rsp_valid at accept+1 edge, data BF800000, int=0, err=0; busy high exactly one cycle before RESP.
- FMUL (funct5 00010), rd=5, ARITH_LAT=2, model 40000000*40400000 → rsp at accept+2 with data 40C00000, rsp_rd=5. Hold rsp_ready_i=0 for 3 cycles → data stable, req_ready_o=0 throughout.
- FEQ (funct5 10100, funct3 010) rd=10 → rsp_int_o=1, data 1 with rs1=rs2=3F800000.
- FDIV: iter_start_o one pulse. Drive iter_done_i 10 cycles later with 3F000000 → rsp data 3F000000, err=0. A spurious iter_done_i while in IDLE → no response.
- Timeout: FSQRT, never assert iter_done_i → after ITER_TIMEOUT cycles iter_abort_o pulses once, rsp data 7FC00000, err=1. Repeat with done coinciding with the last timeout cycle → err=0, no abort.
- Illegal funct5 11111 → rsp err=1, data 0 at accept+1. Assert reset_i during WAIT_ITER of an FDIV → next edge all outputs 0, req_ready_o=1, no abort; a new FEQ then completes normally.
